scope_view_gen: RTL

Parametrised N-channel oscilloscope display generator: owns the VGA raster counters, fetches one sample per pixel per channel from external synchronous wave buffers, and renders dots, linked vertical segments, a per-lane grid and a text overlay into an 8-bit colour index. It sits between the capture wave buffers / text path and the VGA DAC stage, and replaces the fixed two-channel combinational renderer with a pipelined, frame-coherent one.

---
 rtl/scope_view_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/scope_view_gen.sv
// Oscilloscope raster generator: VGA counters, per-channel sample window and
// dot/segment/grid/text renderer feeding a registered 8-bit colour index.
module scope_view_gen #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 9,
  parameter int SHIFT    = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter logic [7:0] CH_COLOR_BASE = 8'd16,
  parameter logic [7:0] TEXT_COLOR    = 8'd4,
  parameter logic [7:0] AXIS_COLOR    = 8'd7,
  parameter logic [7:0] GRID_COLOR    = 8'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         de,
  output logic [7:0]                   color,
  output logic [9:0]                   px,
  output logic [9:0]                   py,
  output logic [9:0]                   smp_addr,
  input  logic [CHANNELS*SAMPLE_W-1:0] smp_data,
  input  logic                         text_on,
  input  logic                         linked,
  input  logic                         grid_on,
  input  logic                         text_off,
  input  logic [CHANNELS-1:0]          ch_en,
  output logic                         frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LANE    = V_ACTIVE / CHANNELS;
  localparam int HSPAN   = (1 << (SAMPLE_W - 1)) >> SHIFT;
  localparam logic signed [SAMPLE_W:0] ONE = 1;

  logic [9:0] r_hc, r_vc;
  logic       w_lineEnd, w_shadowLoad;
  logic [9:0] w_addr;
  logic       w_de0, w_hs0, w_vs0;
  logic       r_de1, r_hs1, r_vs1, r_de2, r_hs2, r_vs2;
  logic [9:0] r_x1, r_y1, r_x2, r_y2;
  logic [CHANNELS-1:0][SAMPLE_W-1:0] r_nxt, r_cur, r_prv;
  logic                r_linked, r_grid, r_textOff;
  logic [CHANNELS-1:0] r_chEn;
  logic [11:0]         w_py12;
  logic [CHANNELS-1:0] w_hit;
  logic                w_axis, w_grid;
  logic [7:0]          w_color;

  assign w_lineEnd    = (r_hc == 10'(H_TOTAL - 1));
  assign w_shadowLoad = w_lineEnd && (r_vc == 10'(V_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_lineEnd) begin
      r_hc <= '0;
      r_vc <= (r_vc == 10'(V_TOTAL - 1)) ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Fetch one pixel ahead; hold the last column through blanking, wrap to 0 just before the line.
  always_comb begin
    w_addr = 10'(H_ACTIVE - 1);
    if (r_hc < 10'(H_ACTIVE - 1)) w_addr = r_hc + 10'd1;
    else if (w_lineEnd)            w_addr = '0;
  end

  assign w_de0 = (r_hc < 10'(H_ACTIVE)) && (r_vc < 10'(V_ACTIVE));
  assign w_hs0 = !((r_hc >= 10'(H_ACTIVE + H_FP)) && (r_hc < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs0 = !((r_vc >= 10'(V_ACTIVE + V_FP)) && (r_vc < 10'(V_ACTIVE + V_FP + V_SYNC)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_de1 <= 1'b0; r_hs1 <= 1'b1; r_vs1 <= 1'b1; r_x1 <= '0; r_y1 <= '0;
      r_de2 <= 1'b0; r_hs2 <= 1'b1; r_vs2 <= 1'b1; r_x2 <= '0; r_y2 <= '0;
      r_nxt <= '0;
      r_cur <= '0;
      r_prv <= '0;
    end else begin
      r_de1 <= w_de0; r_hs1 <= w_hs0; r_vs1 <= w_vs0; r_x1 <= r_hc; r_y1 <= r_vc;
      r_de2 <= r_de1; r_hs2 <= r_hs1; r_vs2 <= r_vs1; r_x2 <= r_x1; r_y2 <= r_y1;
      r_nxt <= smp_data;
      r_cur <= r_nxt;
      r_prv <= r_cur;
    end
  end

  // Render modes only change in vertical blanking so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_linked  <= 1'b0;
      r_grid    <= 1'b0;
      r_textOff <= 1'b0;
      r_chEn    <= '1;
    end else if (w_shadowLoad) begin
      r_linked  <= linked;
      r_grid    <= grid_on;
      r_textOff <= text_off;
      r_chEn    <= ch_en;
    end
  end

  function automatic logic [11:0] yOf(input int c, input logic [SAMPLE_W:0] v);
    return 12'(c * LANE + LANE / 2 + HSPAN) - 12'(v >> SHIFT);
  endfunction

  // Midpoint with the signed difference halved toward zero.
  function automatic logic [SAMPLE_W:0] midOf(input logic [SAMPLE_W-1:0] cur,
                                               input logic [SAMPLE_W-1:0] oth);
    logic signed [SAMPLE_W:0] d, h;
    d = $signed({1'b0, oth}) - $signed({1'b0, cur});
    h = d >>> 1;
    if (d[SAMPLE_W] && d[0]) h = h + ONE;
    return $unsigned($signed({1'b0, cur}) + h);
  endfunction

  function automatic logic inSeg(input logic [11:0] yc, input logic [11:0] ym,
                                 input logic [11:0] yp);
    if (yc <= ym) return (yp >= yc) && (yp <= ym) && (yp != ym);
    else          return (yp >= ym) && (yp <= yc) && (yp != ym);
  endfunction

  assign w_py12 = {2'b00, r_y2};

  always_comb begin
    w_hit   = '0;
    w_axis  = 1'b0;
    w_grid  = 1'b0;
    w_color = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_py12 == yOf(c, {1'b0, r_cur[c]})) w_hit[c] = 1'b1;
      if (r_linked && (r_x2 < 10'(H_ACTIVE - 1)) && (r_nxt[c] != r_cur[c]) &&
          inSeg(yOf(c, {1'b0, r_cur[c]}), yOf(c, midOf(r_cur[c], r_nxt[c])), w_py12))
        w_hit[c] = 1'b1;
      if (r_linked && (r_x2 != '0) && (r_prv[c] != r_cur[c]) &&
          inSeg(yOf(c, {1'b0, r_cur[c]}), yOf(c, midOf(r_cur[c], r_prv[c])), w_py12))
        w_hit[c] = 1'b1;
      w_hit[c] = w_hit[c] & r_chEn[c];
      if (w_py12 == 12'(c * LANE + LANE / 2)) w_axis = 1'b1;
      if (((r_x2[3:0] == 4'd0) || (r_y2[3:0] == 4'd8)) &&
          (w_py12 >= 12'(c * LANE + LANE / 2 - HSPAN)) &&
          (w_py12 <= 12'(c * LANE + LANE / 2 + HSPAN)))
        w_grid = 1'b1;
    end
    if (text_on && !r_textOff) begin
      w_color = TEXT_COLOR;
    end else begin
      for (int c = CHANNELS - 1; c >= 0; c--)
        if (w_hit[c]) w_color = CH_COLOR_BASE + 8'(c);
      if (w_hit == '0) begin
        if (r_grid && w_axis)      w_color = AXIS_COLOR;
        else if (r_grid && w_grid) w_color = GRID_COLOR;
      end
    end
    if (!r_de2) w_color = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      color      <= '0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= r_hs2;
      vsync      <= r_vs2;
      de         <= r_de2;
      color      <= w_color;
      frame_tick <= w_shadowLoad;
    end
  end

  assign px       = r_hc;
  assign py       = r_vc;
  assign smp_addr = w_addr;

endmodule
